// File: rtl/exam_seq_pkg.sv
// Shared types and constants for the exam operation sequencer.
// One state enum, the operand width and the invalid-log marker.
package exam_seq_pkg;
    localparam int W       = 16;
    localparam int POP_LEN = 16;
    localparam int CNT_W   = $clog2(POP_LEN + 1);
    localparam int IDX_W   = $clog2(POP_LEN);

    localparam logic [W-1:0] LOG_INVALID = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        POPA,
        POPB,
        DECIDE,
        POPX,
        LOG,
        FIN
    } state_t;
endpackage

// File: rtl/exam_op_sequencer_popcount_serial.sv
// Bit-serial popcount: 16-bit right shifter plus ones counter.
// cnt already includes the bit currently at the lsb, so on the last shift it is the full count.
module popcount_serial
    import exam_seq_pkg::*;
(
    input  logic             CLOCK_50,
    input  logic             rst,
    input  logic             load,
    input  logic [W-1:0]     din,
    input  logic             shift,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);
    logic [W-1:0]     sr;
    logic [CNT_W-1:0] ones;
    logic [IDX_W-1:0] idx;

    // load wins over shift so a job can be reloaded on its predecessor's final shift
    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            sr   <= '0;
            ones <= '0;
            idx  <= '0;
        end else if (load) begin
            sr   <= din;
            ones <= '0;
            idx  <= '0;
        end else if (shift) begin
            sr   <= sr >> 1;
            ones <= ones + CNT_W'(sr[0]);
            idx  <= idx + IDX_W'(1);
        end
    end

    assign cnt  = ones + CNT_W'(sr[0]);
    assign last = (idx == IDX_W'(POP_LEN - 1));
endmodule

// File: rtl/exam_op_sequencer.sv
// Sequences the shared popcount unit and the log loop to produce g and h.
// Handshake: a run starts on a start rise seen in IDLE; done is held in FIN until start drops.
module exam_op_sequencer
    import exam_seq_pkg::*;
(
    input  logic         CLOCK_50,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    output logic [W-1:0] g,
    output logic [W-1:0] h,
    output logic         done,
    output logic         busy,
    output state_t       state
);
    state_t           state_r;
    state_t           state_n;
    logic             start_q;
    logic [W-1:0]     a_r;
    logic [W-1:0]     b_r;
    logic [W-1:0]     c_r;
    logic [W-1:0]     d_r;
    logic [CNT_W-1:0] acc;
    logic [31:0]      p;
    logic [4:0]       k;

    logic             pop_load;
    logic             pop_shift;
    logic [W-1:0]     pop_din;
    logic [CNT_W-1:0] pop_cnt;
    logic             pop_last;

    logic             par;
    logic             log_skip;
    logic [31:0]      prod;
    logic             prod_fits;

    assign par       = ^(a_r ^ b_r);
    assign log_skip  = (c_r < W'(2)) || (d_r == '0);
    assign prod      = p * {16'd0, c_r};
    assign prod_fits = (prod <= {16'd0, d_r});
    assign state     = state_r;

    popcount_serial u_pop (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .load     (pop_load),
        .din      (pop_din),
        .shift    (pop_shift),
        .cnt      (pop_cnt),
        .last     (pop_last)
    );

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) state_r <= IDLE;
        else      state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE:    if (start && !start_q) state_n = LOAD;
            LOAD:    state_n = POPA;
            POPA:    if (pop_last) state_n = POPB;
            POPB:    if (pop_last) state_n = DECIDE;
            DECIDE: begin
                if (!par)          state_n = POPX;
                else if (log_skip) state_n = FIN;
                else               state_n = LOG;
            end
            POPX:    if (pop_last) state_n = FIN;
            LOG:     if (!prod_fits) state_n = FIN;
            FIN:     if (!start) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // a is taken straight from the port in LOAD since a_r is captured on that same edge
    always_comb begin
        pop_load  = 1'b0;
        pop_shift = 1'b0;
        pop_din   = a;
        busy      = (state_r != IDLE) && (state_r != FIN);
        case (state_r)
            LOAD: pop_load = 1'b1;
            POPA: begin
                pop_shift = 1'b1;
                if (pop_last) begin
                    pop_load = 1'b1;
                    pop_din  = b_r;
                end
            end
            POPB: pop_shift = 1'b1;
            DECIDE: begin
                if (!par) begin
                    pop_load = 1'b1;
                    pop_din  = c_r ^ d_r;
                end
            end
            POPX: pop_shift = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            start_q <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            c_r     <= '0;
            d_r     <= '0;
            acc     <= '0;
            p       <= '0;
            k       <= '0;
            g       <= '0;
            h       <= '0;
            done    <= 1'b0;
        end else begin
            start_q <= start;
            case (state_r)
                LOAD: begin
                    a_r  <= a;
                    b_r  <= b;
                    c_r  <= c;
                    d_r  <= d;
                    g    <= '0;
                    h    <= '0;
                    done <= 1'b0;
                end
                POPA: if (pop_last) acc <= pop_cnt;
                DECIDE: begin
                    g <= W'(acc) + W'(pop_cnt);
                    if (par && log_skip) begin
                        h    <= LOG_INVALID;
                        done <= 1'b1;
                    end else if (par) begin
                        p <= 32'd1;
                        k <= '0;
                    end
                end
                POPX: begin
                    if (pop_last) begin
                        h    <= W'(pop_cnt);
                        done <= 1'b1;
                    end
                end
                LOG: begin
                    if (prod_fits) begin
                        p <= prod;
                        k <= k + 5'd1;
                    end else begin
                        h    <= W'(k);
                        done <= 1'b1;
                    end
                end
                FIN: if (!start) done <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_exam_op_sequencer.sv
// Directed bench for exam_op_sequencer: a vector table of operands with
// hand-computed g/h/done edges, plus mid-run reset and ignored-start sequences.
module tb_exam_op_sequencer;
    import exam_seq_pkg::*;

    logic         CLOCK_50;
    logic         rst;
    logic         start;
    logic [15:0]  a, b, c, d;
    logic [15:0]  g, h;
    logic         done;
    logic         busy;
    state_t       dut_state;

    int total_checks;
    int passed_checks;

    typedef struct {
        logic [15:0] a, b, c, d;
        logic [15:0] g, h;
        int          done_at;
    } vec_t;

    vec_t vecs[9];

    exam_op_sequencer dut (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .g        (g),
        .h        (h),
        .done     (done),
        .busy     (busy),
        .state    (dut_state)
    );

    // clock / reset
    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act === exp) passed_checks++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // driver: present operands and raise start away from the active edge
    task automatic launch(input vec_t v);
        @(negedge CLOCK_50);
        a = v.a; b = v.b; c = v.c; d = v.d;
        start = 1'b1;
    endtask

    // next posedge is E0; count edges until done, then drop start and check hold
    task automatic wait_done(input vec_t v, input string tag, input int pulse_at);
        int done_edge;
        done_edge = -1;
        @(posedge CLOCK_50);
        #1;
        check({tag, " busy@E0"}, 32'(busy), 32'd1);
        for (int e = 1; e <= 60 && done_edge < 0; e++) begin
            @(posedge CLOCK_50);
            #1;
            if (e == 34) check({tag, " g@E34"}, 32'(g), 32'(v.g));
            if (e == pulse_at) start = 1'b0;
            if (e == pulse_at + 1) start = 1'b1;
            if (done) done_edge = e;
        end
        check({tag, " done_edge"}, 32'(done_edge), 32'(v.done_at));
        check({tag, " g"}, 32'(g), 32'(v.g));
        check({tag, " h"}, 32'(h), 32'(v.h));
        check({tag, " busy@done"}, 32'(busy), 32'd0);
        @(negedge CLOCK_50);
        start = 1'b0;
        @(posedge CLOCK_50);
        #1;
        check({tag, " done_clr"}, 32'(done), 32'd0);
        check({tag, " g_hold"}, 32'(g), 32'(v.g));
        check({tag, " h_hold"}, 32'(h), 32'(v.h));
    endtask

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        vecs[0] = '{16'hFFFF, 16'h0001, 16'h0003, 16'h0005, 16'h0011, 16'h0001, 36};
        vecs[1] = '{16'h00FF, 16'h0000, 16'hF0F0, 16'h0F0F, 16'h0008, 16'h0010, 50};
        vecs[2] = '{16'h0001, 16'h0000, 16'h0001, 16'h1234, 16'h0001, 16'hFFFF, 34};
        vecs[3] = '{16'h0001, 16'h0000, 16'h0002, 16'hFFFF, 16'h0001, 16'h000F, 50};
        vecs[4] = '{16'h0007, 16'h0000, 16'h0005, 16'h0000, 16'h0003, 16'hFFFF, 34};
        vecs[5] = '{16'h0001, 16'h0000, 16'h000A, 16'h0005, 16'h0001, 16'h0000, 35};
        vecs[6] = '{16'hAAAA, 16'h5555, 16'h1234, 16'h1234, 16'h0010, 16'h0000, 50};
        vecs[7] = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0020, 16'h0000, 50};
        vecs[8] = '{16'h0001, 16'h0000, 16'h000A, 16'h03E8, 16'h0001, 16'h0003, 38};

        rst = 1'b0; start = 1'b0;
        a = '0; b = '0; c = '0; d = '0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("rst g", 32'(g), 32'd0);
        check("rst h", 32'(h), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst state", 32'(dut_state), 32'(IDLE));
        @(negedge CLOCK_50);
        rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            launch(vecs[i]);
            wait_done(vecs[i], $sformatf("vec%0d", i), -10);
        end

        // reset at E20 of a run, then release with start still high
        launch(vecs[1]);
        @(posedge CLOCK_50);
        repeat (20) @(posedge CLOCK_50);
        #2;
        rst = 1'b0;
        #1;
        check("midrst g", 32'(g), 32'd0);
        check("midrst h", 32'(h), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst state", 32'(dut_state), 32'(IDLE));
        @(negedge CLOCK_50);
        rst = 1'b1;
        wait_done(vecs[1], "restart", -10);

        // start pulse in the middle of a run must not disturb it
        launch(vecs[3]);
        wait_done(vecs[3], "pulse", 20);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end
endmodule

// File: doc/exam_op_sequencer.md
# exam_op_sequencer

Controller that sequences one shared bit-serial popcount unit and a multiplicative log loop to compute the exam results `g` and `h` from the four captured operands. It sits in place of the student module under the DE2 exam wrapper: the same `start`/`done` contract, operands `a`–`d` from the switch-entry FSM, and `g`/`h` shown on LEDR. It arbitrates the single popcount shifter among three jobs, popcount(a), popcount(b) and popcount(c^d). A parity decision picks the final job.

## Interface
- `W`, 16, operand/result width (only 16 supported; `POP_LEN = W`)
- `CLOCK_50` in 1: system clock
- `rst` in 1: reset, asynchronous, active-low. Clock is `CLOCK_50`.
- `start` in 1: level request; a run begins on its rising edge
- `a`, `b`, `c`, `d` in W: operands, sampled once in LOAD
- `g` out W: popcount(a)+popcount(b), zero-extended
- `h` out W: parity-selected result (see Operation)
- `done` out 1: high in FIN
- `busy` out 1: high in every state except IDLE and FIN

## Operation
- Edge detect: `start_q` register, reset 0. A rising edge is `start & ~start_q` sampled in IDLE. If `start` is high when reset releases, that counts as a rising edge.
- LOAD: capture `a`..`d` into internal regs; clear `g`, `h`, `done`; load the shifter with `a`.
- POPA, 16 cycles: shift right, `cnt += lsb`. On exit, `acc <= cnt`, load shifter with `b`, `cnt <= 0`.
- POPB, 16 cycles: same; on exit go to DECIDE.
- DECIDE, 1 cycle: `g <= acc + cnt` (max 32, 6 bits, zero-extended). `par = ^(a_r ^ b_r)`.
  - `par==0`: load shifter with `c_r ^ d_r`, go to POPX.
  - `par==1` and (`c_r<2` or `d_r==0`): `h <= 16'hFFFF`, `done <= 1`, go to FIN.
  - `par==1` otherwise: `p <= 1` (32-bit), `k <= 0`, go to LOG.
- POPX, 16 cycles: on exit `h <= cnt`, `done <= 1`, go to FIN.
- LOG: each cycle, if `p*c_r <= d_r` then `p <= p*c_r`, `k <= k+1`. Otherwise `h <= k`, `done <= 1`, go to FIN. The product is 32-bit and cannot overflow, since `p <= 65535` and `c <= 65535`. `k` is at most 15.
- FIN: hold `g`, `h`, `done`. When `start` is low, go to IDLE with `done <= 0`; `g` and `h` hold until the next LOAD.
- A `start` rising edge is ignored in every state except IDLE.
- Reset mid-run: every register clears immediately, state goes to IDLE, and no partial results are kept.

## Timing
- Reset values: `g=0`, `h=0`, `done=0`, `busy=0`, state IDLE.
- Edge numbering: E0 is the clock edge that samples the `start` rise (IDLE→LOAD). Counted from E0:

| Edge | Event |
|---|---|
| E1 | LOAD executes |
| E2–E17 | POPA |
| E18–E33 | POPB |
| E34 | DECIDE; `g` valid after E34 |
| E35–E50 (par=0) | POPX; `done` high after E50 |
| E35–E(35+k) (LOG) | LOG loop; `done` high after E(35+k) |

- Special case (`c_r<2` or `d_r==0` with `par==1`): `done` high after E34.
- `done` and final `h` update on the same edge.
- `busy` falls on the same edge `done` rises.
- Worst-case latency: 50 edges.

## Structure
- Package `exam_seq_pkg` holds:
  - state enum: IDLE, LOAD, POPA, POPB, DECIDE, POPX, LOG, FIN
  - `W = 16`, `POP_LEN = 16`
  - `LOG_INVALID = 16'hFFFF`
- One sub-module, `popcount_serial`: a 16-bit shift register plus 5-bit counter with ports `load`, `din`, `shift` and outputs `cnt`, `last`. The sequencer owns the mux that selects its load source (`a_r`, `b_r`, or `c_r^d_r`).
- The LOG multiplier is inline in the sequencer.

## Test plan
- a=FFFF, b=0001, c=0003, d=0005 → g=0x0011; par=1; h=0x0001 (log3 5); `done` after E36.
- a=00FF, b=0000, c=F0F0, d=0F0F → g=0x0008; par=0; h=0x0010; `done` after E50.
- a=0001, b=0000, c=0001, d=1234 → g=0x0001; h=0xFFFF; `done` after E34.
- a=0001, b=0000, c=0002, d=FFFF → h=0x000F; `done` after E50, which is the worst case.
- Assert `rst` at E20 → all outputs 0 within the same cycle. Release `rst` with `start` held high → run restarts, and the second-row vector gives identical results.
- Complete a run, drop `start` → `done=0`, `g`/`h` held. Change operands and raise `start` → new results. A `start` pulse while `busy` is ignored.
